// File: rtl/vga_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_addr_gen
// Purpose  : Reads an image header once per frame, then issues one sequential
//            pixel read per in-window pix_tick with latency-aligned pixel_en.
// Revision : 1.0 - initial release
// ============================================================================
module vga_addr_gen #(
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 19,
  parameter int DIM_W       = 16,
  parameter int H_START     = 145,
  parameter int V_START     = 35,
  parameter int HDR_ADDR    = 2,
  parameter int BASE_ORIG   = 6,
  parameter int BASE_INTERP = 250505,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DIM     = 400
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_tick,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               mode,
  input  logic [DIM_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               pixel_en,
  output logic               frame_start,
  output logic [DIM_W-1:0]   dim_active
);

  localparam int CNT_W = 3;
  localparam int CMP_W = COORD_W + DIM_W + 1;

  typedef enum logic [1:0] {
    BLANK    = 2'd0,
    HDR_WAIT = 2'd1,
    READY    = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  addr_ptr_q, addr_ptr_d;
  logic [DIM_W-1:0]   dim_orig_q, dim_orig_d;
  logic               mode_frame_q, mode_frame_d;
  logic               frame_start_q, frame_start_d;
  logic [MEM_LAT:0]   pipe_q, pipe_d;

  logic [DIM_W-1:0]   quarter, triple, dim_interp, dim_sel;
  logic [CMP_W-1:0]   x_e, y_e, h_lo, h_hi, v_lo, v_hi;
  logic               y_blank, in_win, issue;

  // 3*(d>>2) never exceeds DIM_W bits; it is either 0 or >= 3, so only the
  // zero case can go negative after subtracting 2.
  always_comb begin
    quarter    = dim_orig_q >> 2;
    triple     = quarter + (quarter << 1);
    dim_interp = (triple < DIM_W'(2)) ? '0 : triple - DIM_W'(2);
    dim_sel    = mode_frame_q ? dim_interp : dim_orig_q;
    dim_active = (dim_sel > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : dim_sel;
  end

  always_comb begin
    x_e     = CMP_W'(x);
    y_e     = CMP_W'(y);
    h_lo    = CMP_W'(H_START);
    v_lo    = CMP_W'(V_START);
    h_hi    = h_lo + CMP_W'(dim_active);
    v_hi    = v_lo + CMP_W'(dim_active);
    y_blank = (y_e < v_lo);
    in_win  = (x_e >= h_lo) && (x_e < h_hi) && (y_e >= v_lo) && (y_e < v_hi);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    addr_ptr_d    = addr_ptr_q;
    dim_orig_d    = dim_orig_q;
    mode_frame_d  = mode_frame_q;
    frame_start_d = 1'b0;
    issue         = 1'b0;

    case (state_q)
      BLANK: begin
        if (pix_tick && y_blank) begin
          mem_addr_d = ADDR_W'(HDR_ADDR);
          cnt_d      = CNT_W'(MEM_LAT);
          state_d    = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (cnt_q == '0) begin
          dim_orig_d    = mem_rdata;
          mode_frame_d  = mode;
          frame_start_d = 1'b1;
          addr_ptr_d    = mode ? ADDR_W'(BASE_INTERP) : ADDR_W'(BASE_ORIG);
          state_d       = READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READY: begin
        if (pix_tick && !y_blank) begin
          state_d = ACTIVE;
          issue   = in_win;
        end
      end
      ACTIVE: begin
        if (pix_tick) begin
          if (y_blank) state_d = BLANK;
          else         issue   = in_win;
        end
      end
      default: state_d = BLANK;
    endcase

    if (issue) begin
      mem_addr_d = addr_ptr_q;
      addr_ptr_d = addr_ptr_q + ADDR_W'(1);
    end

    // Stage 0 is the issue-valid bit; stage MEM_LAT lines up with mem_rdata.
    pipe_d = {pipe_q[MEM_LAT-1:0], issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      addr_ptr_q    <= ADDR_W'(BASE_ORIG);
      dim_orig_q    <= '0;
      mode_frame_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pipe_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      addr_ptr_q    <= addr_ptr_d;
      dim_orig_q    <= dim_orig_d;
      mode_frame_q  <= mode_frame_d;
      frame_start_q <= frame_start_d;
      pipe_q        <= pipe_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign pixel_en    = pipe_q[MEM_LAT];
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_addr_gen
// Purpose  : Scoreboard bench for vga_addr_gen on a reduced frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_addr_gen;

  localparam int COORD_W = 6;
  localparam int ADDR_W  = 19;
  localparam int DIM_W   = 16;
  localparam int H_START = 4;
  localparam int V_START = 2;
  localparam int HDR_A   = 2;
  localparam int B_ORIG  = 6;
  localparam int B_INTP  = 250505;
  localparam int LAT     = 3;
  localparam int MAXD    = 12;
  localparam int COLS    = 18;
  localparam int ROWS    = 16;
  localparam int NFR     = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               pix_tick = 1'b0;
  logic [COORD_W-1:0] x = '0;
  logic [COORD_W-1:0] y = '0;
  logic               mode = 1'b0;
  logic [DIM_W-1:0]   mem_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic               pixel_en;
  logic               frame_start;
  logic [DIM_W-1:0]   dim_active;

  vga_addr_gen #(
    .COORD_W(COORD_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
    .H_START(H_START), .V_START(V_START), .HDR_ADDR(HDR_A),
    .BASE_ORIG(B_ORIG), .BASE_INTERP(B_INTP), .MEM_LAT(LAT), .MAX_DIM(MAXD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .x(x), .y(y),
    .mode(mode), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .pixel_en(pixel_en), .frame_start(frame_start), .dim_active(dim_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: address pipeline of depth LAT; header word at HDR_A.
  logic [DIM_W-1:0]  hdr_cur = '0;
  logic [ADDR_W-1:0] ap [LAT];
  initial for (int i = 0; i < LAT; i++) ap[i] = '0;
  always @(posedge clk) begin
    ap[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end
  assign mem_rdata = (ap[LAT-1] == ADDR_W'(HDR_A)) ? hdr_cur : ap[LAT-1][DIM_W-1:0];

  logic [ADDR_W-1:0] exp_addr [$];
  int                exp_cyc  [$];
  logic [DIM_W-1:0]  fs_dim   [$];
  int                fs_cyc   [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents a pixel or header latch.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_en) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_pixel_en", 32'd1, 32'd0);
        end else begin
          chk("pixel_addr", 32'(ap[LAT-1]), 32'(exp_addr.pop_front()));
          chk("pixel_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
        end
      end
      if (frame_start) begin
        if (fs_dim.size() == 0) begin
          chk("unexpected_frame_start", 32'd1, 32'd0);
        end else begin
          chk("dim_active", 32'(dim_active), 32'(fs_dim.pop_front()));
          chk("frame_start_cycle", 32'(cyc), 32'(fs_cyc.pop_front()));
        end
      end
    end
  end

  // Directed frame table: header word, mode at frame start, hand-computed
  // window dimension and start address.
  int hdr_t  [NFR] = '{8, 8, 4, 2, 20, 16, 6, 6, 8, 9};
  int mode_t [NFR] = '{0, 1, 1, 1, 0,  1,  0, 1, 0, 0};
  int dim_t  [NFR] = '{8, 4, 1, 0, 12, 10, 6, 1, 8, 9};
  int base_t [NFR] = '{6, 250505, 250505, 250505, 6, 250505, 6, 250505, 6, 6};

  task automatic do_tick(input int xx, input int yy, input bit push, input logic [ADDR_W-1:0] a);
    x        = COORD_W'(xx);
    y        = COORD_W'(yy);
    pix_tick = 1'b1;
    if (push) begin
      exp_addr.push_back(a);
      exp_cyc.push_back(cyc + 1 + LAT);
    end
    @(posedge clk); #1;
    pix_tick = 1'b0;
  endtask

  initial begin
    bit                fresh;
    bit                armed;
    int                tick_n;
    logic [ADDR_W-1:0] ptr;

    #1;
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_pixel_en", 32'(pixel_en), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    chk("reset_dim_active", 32'(dim_active), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    fresh = 1'b1;
    for (int f = 0; f < NFR; f++) begin
      hdr_cur = DIM_W'(hdr_t[f]);
      mode    = mode_t[f][0];
      ptr     = ADDR_W'(base_t[f]);
      armed   = 1'b1;
      tick_n  = 0;
      for (int yy = 0; yy < ROWS; yy++) begin
        for (int xx = 0; xx < COLS; xx++) begin
          bit inwin;
          // Mode flip mid-frame must not affect the frame in progress.
          if (f == 6 && yy == V_START + 3 && xx == 0) mode = 1'b1;
          if (f == 8 && yy == 5 && xx == 6) begin
            rst_n = 1'b0;
            #1;
            chk("midreset_mem_addr", 32'(mem_addr), 32'd0);
            chk("midreset_pixel_en", 32'(pixel_en), 32'd0);
            chk("midreset_dim_active", 32'(dim_active), 32'd0);
            chk("midreset_frame_start", 32'(frame_start), 32'd0);
            exp_addr.delete();
            exp_cyc.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            armed = 1'b0;
          end
          if (armed && tick_n == (fresh ? 0 : 1)) begin
            fs_dim.push_back(DIM_W'(dim_t[f]));
            fs_cyc.push_back(cyc + 2 + LAT);
          end
          inwin = armed && xx >= H_START && xx < H_START + dim_t[f] &&
                  yy >= V_START && yy < V_START + dim_t[f];
          do_tick(xx, yy, inwin, ptr);
          if (inwin) ptr = ptr + 1'b1;
          if (xx % 3 != 0) begin
            @(posedge clk); #1;
          end
          tick_n++;
        end
      end
      fresh = !armed;
    end

    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("pixels_outstanding", 32'(exp_addr.size()), 32'd0);
    chk("headers_outstanding", 32'(fs_dim.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_addr_gen.md
VGA_ADDR_GEN -- requirements
Module: vga_addr_gen

Interface
REQ-001 Parameter COORD_W, default 10, width of pixel coordinates x/y.
REQ-002 Parameter ADDR_W, default 19, memory address width.
REQ-003 Parameter DIM_W, default 16, width of image-dimension word read from memory.
REQ-004 Parameter H_START, default 145, first active column; V_START, default 35, first active row.
REQ-005 Parameter HDR_ADDR, default 2, address of dimension header word.
REQ-006 Parameter BASE_ORIG, default 6; BASE_INTERP, default 250505; start addresses of original / interpolated image.
REQ-007 Parameter MEM_LAT, default 1 (range 1-4), memory read latency in clk cycles.
REQ-008 Parameter MAX_DIM, default 400, largest displayable dimension.
REQ-009 clk  in  1  single clock; reset is asynchronous and active-low.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 pix_tick  in  1  one-cycle strobe, x/y valid for new pixel.
REQ-012 x, y  in  COORD_W each  current VGA column/row.
REQ-013 mode  in  1  0 = original image, 1 = interpolated quadrant.
REQ-014 mem_rdata  in  DIM_W  read data from memory.
REQ-015 mem_addr  out  ADDR_W  registered read address.
REQ-016 pixel_en  out  1  high when mem_rdata carries a pixel for the current display position (latency-aligned).
REQ-017 frame_start  out  1  one-cycle pulse when header dimension is latched.
REQ-018 dim_active  out  DIM_W  dimension of window used in current frame.

Function
REQ-019 FSM states: BLANK, HDR_WAIT, READY, ACTIVE; all transitions on clk rising edge.
REQ-020 BLANK: on pix_tick with y < V_START, drive mem_addr = HDR_ADDR, load latency counter = MEM_LAT, go HDR_WAIT.
REQ-021 HDR_WAIT: decrement counter each cycle; at zero latch mem_rdata into dim_orig, sample mode into mode_frame, pulse frame_start, go READY.
REQ-022 Dimension rule: dim_interp = 3*(dim_orig>>2) - 2 computed in DIM_W+2 bits; result < 0 forced to 0.
REQ-023 dim_active = mode_frame ? dim_interp : dim_orig, clamped to MAX_DIM.
REQ-024 READY: set addr_ptr = mode_frame ? BASE_INTERP : BASE_ORIG; go ACTIVE on first pix_tick with y >= V_START.
REQ-025 In-window test: H_START <= x < H_START+dim_active and V_START <= y < V_START+dim_active, comparisons at COORD_W+DIM_W+1 bits (no truncation).
REQ-026 ACTIVE, pix_tick in window: mem_addr <= addr_ptr, addr_ptr <= addr_ptr+1 (modulo 2^ADDR_W), issue-valid bit = 1.
REQ-027 ACTIVE, pix_tick outside window: mem_addr and addr_ptr hold, issue-valid bit = 0.
REQ-028 pixel_en = issue-valid bit delayed MEM_LAT cycles through a shift register; exactly one pixel_en per in-window pix_tick.
REQ-029 ACTIVE -> BLANK when pix_tick arrives with y < V_START (next frame's blanking); header re-read every frame.
REQ-030 mode changes during HDR_WAIT/READY/ACTIVE ignored until next header latch.
REQ-031 dim_active = 0: no in-window pixels, pixel_en stays 0 for whole frame.
REQ-032 pix_tick arriving in HDR_WAIT ignored; no pixel issued before header latched.
REQ-033 pix_tick absent: all state, addr_ptr, mem_addr hold (except HDR_WAIT counter and pixel_en pipeline, which advance every clk).

Reset
REQ-034 rst_n low asynchronously: state = BLANK, mem_addr = 0, addr_ptr = BASE_ORIG, dim_orig = 0, mode_frame = 0, pixel_en = 0, frame_start = 0, dim_active = 0, pipeline cleared.
REQ-035 Reset asserted mid-frame aborts frame; after release no pixel_en until a full header read completes.

Verification
REQ-036 mode=0, header=392, MEM_LAT=1, scan a frame -> first in-window address 6, last 6+392*392-1 = 153669, 153664 pixel_en pulses each 1 cycle after issue.
REQ-037 mode=1, header=392 -> dim_active=292, first address 250505, 85264 pulses, no pixel at x=437 or y=327.
REQ-038 header=4 then header=2 in next frame, mode=1 -> dim_active=1 then 0; second frame yields zero pixel_en.
REQ-039 toggle mode 0->1 at row 100 of ACTIVE frame -> current frame completes with original addresses; next frame starts at 250505.
REQ-040 MEM_LAT=3 -> header latched 3 cycles after HDR_ADDR issued; pixel_en lags each in-window pix_tick by 3 cycles.
REQ-041 assert rst_n=0 at x=200,y=100 mid-ACTIVE -> outputs reset values immediately; after release pixel_en=0 until next frame_start.
